mips_lsu: RTL

- Load/store unit for the single-cycle/multicycle MIPS core.
- Consumes the decoded memory operation (op class, effective address, store data) and runs the data-memory request/grant/response protocol.
- Generates the byte-lane write enables that the decode stage does not drive, then aligns and extends load data for register writeback.
- Sits between execute (address from ALU ADD) and the data memory port; its stall output freezes the PC and pipeline while an access is in flight.

---
 rtl/mips_lsu_pkg.sv | 39 +++
 rtl/mips_lsu_align.sv | 53 +++++
 rtl/mips_lsu.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared load/store encodings and LSU state definitions.
// The decoder imports the same LS_* constants so it can drive ls_op directly.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        LS_LB  = 3'd0,
        LS_LH  = 3'd1,
        LS_LW  = 3'd2,
        LS_LBU = 3'd3,
        LS_LHU = 3'd4,
        LS_SB  = 3'd5,
        LS_SH  = 3'd6,
        LS_SW  = 3'd7
    } ls_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        ERR  = 3'd3,
        RESP = 3'd4
    } state_e;

    function automatic logic is_store(input ls_op_e op);
        return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
    endfunction

    // Halves need an even address, words need a word-aligned address.
    function automatic logic is_misaligned(input ls_op_e op, input logic [1:0] off);
        logic mis;
        case (op)
            LS_LH, LS_LHU, LS_SH: mis = off[0];
            LS_LW, LS_SW:         mis = |off;
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Byte-lane write-enable/data generation and load byte/half extraction.
// Purely combinational; fed from the LSU's latched request.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  ls_op_e      ls_op,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (byte_off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        we       = '0;
        wdata    = store_data;
        load_ext = rdata;
        case (ls_op)
            LS_LB:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            LS_LBU: load_ext = {24'd0, byte_sel};
            LS_LH:  load_ext = {{16{half_sel[15]}}, half_sel};
            LS_LHU: load_ext = {16'd0, half_sel};
            LS_SB: begin
                we    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            LS_SH: begin
                we    = 4'b0011 << {byte_off[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            LS_SW: begin
                we    = 4'b1111;
                wdata = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: request FSM, memory handshake and timeout watchdog.
// Lane steering and load extension live in mips_lsu_align.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  ls_op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        bus_err,
    output logic        stall
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    state_e        state_q, state_d;
    ls_op_e        op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   sdata_q, sdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [31:0]   ldata_q, ldata_d;
    logic          berr_q, berr_d;

    logic [3:0]    we_w;
    logic [31:0]   wdata_w;
    logic [31:0]   load_ext_w;

    mips_lsu_align u_align (
        .ls_op      (op_q),
        .byte_off   (addr_q[1:0]),
        .store_data (sdata_q),
        .rdata      (mem_rdata),
        .we         (we_w),
        .wdata      (wdata_w),
        .load_ext   (load_ext_w)
    );

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        cnt_d   = cnt_q;
        ldata_d = ldata_q;
        berr_d  = berr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = ls_op_e'(ls_op);
                    addr_d  = addr;
                    sdata_d = store_data;
                    cnt_d   = '0;
                    ldata_d = '0;
                    berr_d  = 1'b0;
                    state_d = is_misaligned(ls_op_e'(ls_op), addr[1:0]) ? ERR : REQ;
                end
            end
            // A grant or read response in the final counted cycle still wins over the timeout.
            REQ: begin
                if (mem_gnt) begin
                    cnt_d   = '0;
                    state_d = is_store(op_q) ? RESP : WAIT;
                end else if (cnt_inc == TO_VAL) begin
                    berr_d  = 1'b1;
                    ldata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    ldata_d = load_ext_w;
                    state_d = RESP;
                end else if (cnt_inc == TO_VAL) begin
                    berr_d  = 1'b1;
                    ldata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ERR:     state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= LS_LB;
            addr_q  <= '0;
            sdata_q <= '0;
            cnt_q   <= '0;
            ldata_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            cnt_q   <= cnt_d;
            ldata_q <= ldata_d;
            berr_q  <= berr_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q != IDLE) || req_valid;
    assign mem_req    = (state_q == REQ);
    assign mem_addr   = addr_q[31:2];
    assign mem_we     = (state_q == REQ) ? we_w : '0;
    assign mem_wdata  = wdata_w;
    assign resp_valid = (state_q == RESP) || (state_q == ERR);
    assign addr_err   = (state_q == ERR);
    assign bus_err    = (state_q == RESP) && berr_q;
    assign load_data  = ldata_q;

endmodule
